// File: rtl/pwm_gen.sv
// PWM output stage: compares the external counter against shadowed thresholds.
// Shadows reload on enable and on every counter wrap, so mid-period writes take effect cleanly.
module pwm_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] count_val,
  input  logic [15:0] period,
  input  logic        upnotdown,
  input  logic        pwm_en,
  input  logic [1:0]  functions,
  input  logic [15:0] compare1,
  input  logic [15:0] compare2,
  output logic        pwm_out,
  output logic        period_tick
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [15:0] r_prev_count;
  logic [15:0] r_cmp1_sh;
  logic [15:0] r_cmp2_sh;
  logic [1:0]  r_mode_sh;

  logic        w_wrap;
  logic        w_run_wrap;
  logic        w_load;
  logic [15:0] w_cmp1;
  logic [15:0] w_cmp2;
  logic [1:0]  w_mode;
  logic        w_duty;

  // Only a moving counter can wrap; a held value never re-triggers
  assign w_wrap = (count_val != r_prev_count) &&
                  (upnotdown ? (count_val == 16'd0)
                             : (count_val == period));

  assign w_run_wrap = (r_state == ST_RUN) && pwm_en && w_wrap;
  assign w_load     = ((r_state == ST_IDLE) && pwm_en) || w_run_wrap;

  assign w_cmp1 = w_load ? compare1  : r_cmp1_sh;
  assign w_cmp2 = w_load ? compare2  : r_cmp2_sh;
  assign w_mode = w_load ? functions : r_mode_sh;

  always_comb begin
    w_duty = 1'b0;
    if (w_mode[1])
      w_duty = (count_val >= w_cmp1) && (count_val < w_cmp2);
    else if (w_mode[0])
      w_duty = (count_val >= w_cmp1);
    else
      w_duty = (count_val < w_cmp1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (pwm_en)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!pwm_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prev_count <= 16'd0;
      r_cmp1_sh    <= 16'd0;
      r_cmp2_sh    <= 16'd0;
      r_mode_sh    <= 2'b00;
      pwm_out      <= 1'b0;
      period_tick  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_count <= count_val;
      if (w_load) begin
        r_cmp1_sh <= compare1;
        r_cmp2_sh <= compare2;
        r_mode_sh <= functions;
      end
      pwm_out     <= pwm_en && w_duty;
      period_tick <= w_run_wrap;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed vector table, hand sequences for corner cases,
// and a randomized run against a cycle-level reference model.
module tb_pwm_gen;

  logic        clk;
  logic        rst;
  logic [15:0] count_val;
  logic [15:0] period;
  logic        upnotdown;
  logic        pwm_en;
  logic [1:0]  functions;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic        pwm_out;
  logic        period_tick;

  int n_checks = 0;
  int n_errors = 0;

  pwm_gen dut (
    .clk        (clk),
    .rst        (rst),
    .count_val  (count_val),
    .period     (period),
    .upnotdown  (upnotdown),
    .pwm_en     (pwm_en),
    .functions  (functions),
    .compare1   (compare1),
    .compare2   (compare2),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] cnt;
    logic [1:0]  mode;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [15:0] per;
    logic        dir;
    logic        ep;
    logic        et;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  bit       m_run;
  int       m_prev;
  int       m_c1, m_c2;
  bit [1:0] m_mode;
  bit       m_pwm, m_tick;

  function automatic bit duty(bit [1:0] m, int c1, int c2, int c);
    if (m == 2'b00) return c < c1;
    if (m == 2'b01) return c >= c1;
    return (c >= c1) && (c < c2);
  endfunction

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_c1 = 0; m_c2 = 0; m_mode = 2'b00;
    m_pwm = 0; m_tick = 0;
  endtask

  task automatic model_eval();
    bit wrap;
    int c;
    c = int'(count_val);
    wrap = (c != m_prev) &&
           (upnotdown ? (c == 0) : (c == int'(period)));
    if (!pwm_en) begin
      m_pwm = 0; m_tick = 0; m_run = 0;
    end else begin
      if (!m_run || wrap) begin
        m_c1 = int'(compare1); m_c2 = int'(compare2); m_mode = functions;
      end
      m_tick = m_run && wrap;
      m_pwm  = duty(m_mode, m_c1, m_c2, c);
      m_run  = 1;
    end
    m_prev = c;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(logic en, int cnt, logic [1:0] mode,
                              int c1, int c2, int per, logic dir,
                              logic ep, logic et);
    vec_t v;
    v.en = en; v.cnt = 16'(cnt); v.mode = mode;
    v.c1 = 16'(c1); v.c2 = 16'(c2); v.per = 16'(per);
    v.dir = dir; v.ep = ep; v.et = et;
    tbl.push_back(v);
  endfunction

  task automatic set_cfg(logic [1:0] m, int c1, int c2, int per, logic dir);
    functions = m; compare1 = 16'(c1); compare2 = 16'(c2);
    period = 16'(per); upnotdown = dir;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; count_val = 0; period = 9; upnotdown = 1; pwm_en = 0;
    functions = 0; compare1 = 0; compare2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm", pwm_out, 1'b0);
    check("reset_tick", period_tick, 1'b0);
    rst = 1'b0;

    // left-aligned, period 9, compare1 3, up-count
    for (int i = 0; i < 12; i++)
      add(1, i % 10, 2'b00, 3, 0, 9, 1, (i % 10) < 3, i == 10);
    add(0, 2, 2'b00, 3, 0, 9, 1, 0, 0);
    // unaligned 2..5
    for (int i = 0; i < 11; i++)
      add(1, i % 10, 2'b10, 2, 6, 9, 1,
          ((i % 10) >= 2) && ((i % 10) < 6), i == 10);
    add(0, 1, 2'b10, 2, 6, 9, 1, 0, 0);
    // down-count, right-aligned, high for 9..5
    for (int i = 0; i < 12; i++)
      add(1, 9 - (i % 10), 2'b01, 5, 0, 9, 0,
          (9 - (i % 10)) >= 5, i == 10);
    add(0, 8, 2'b01, 5, 0, 9, 0, 0, 0);

    foreach (tbl[k]) begin
      pwm_en = tbl[k].en; count_val = tbl[k].cnt;
      set_cfg(tbl[k].mode, int'(tbl[k].c1), int'(tbl[k].c2),
              int'(tbl[k].per), tbl[k].dir);
      step();
      check("vec_pwm", pwm_out, tbl[k].ep);
      check("vec_tick", period_tick, tbl[k].et);
    end

    // shadowing: compare1 written at count 4, takes effect after the wrap
    set_cfg(2'b00, 3, 0, 9, 1);
    pwm_en = 1;
    for (int i = 0; i < 20; i++) begin
      count_val = 16'(i % 10);
      if (i == 4) compare1 = 7;
      step();
      check("shadow_pwm", pwm_out, (i % 10) < (i >= 10 ? 7 : 3));
      check("shadow_tick", period_tick, i == 10);
    end

    // boundary compares
    pwm_en = 0; step();
    set_cfg(2'b00, 0, 0, 9, 1);
    pwm_en = 1;
    for (int i = 0; i < 25; i++) begin
      count_val = 16'(i % 10); step();
      check("cmp_zero", pwm_out, 1'b0);
    end
    pwm_en = 0; step();
    compare1 = 10; pwm_en = 1;
    for (int i = 0; i < 25; i++) begin
      count_val = 16'(i % 10); step();
      check("cmp_over", pwm_out, 1'b1);
    end

    // async reset during a high pulse
    pwm_en = 0; step();
    set_cfg(2'b00, 5, 0, 9, 1);
    pwm_en = 1;
    for (int i = 0; i < 3; i++) begin
      count_val = 16'(i); step();
    end
    check("pre_rst_high", pwm_out, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm_out, 1'b0);
    check("async_rst_tick", period_tick, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    count_val = 3; step();
    check("post_rst_pwm", pwm_out, m_pwm);

    // pwm_en dropped in a wrap cycle
    for (int i = 4; i < 10; i++) begin
      count_val = 16'(i); step();
    end
    count_val = 0; pwm_en = 0; step();
    check("dis_wrap_tick", period_tick, 1'b0);
    check("dis_wrap_pwm", pwm_out, 1'b0);

    // static counter: no further tick after a wrap
    pwm_en = 1; count_val = 5; step(); step();
    count_val = 0; step();
    check("static_tick0", period_tick, 1'b1);
    repeat (4) begin
      step();
      check("static_tick", period_tick, 1'b0);
    end

    // randomized against the model
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        period = 16'($urandom_range(3, 20));
        functions = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 149) == 0) upnotdown = ~upnotdown;
      if ($urandom_range(0, 29) == 0) begin
        compare1 = 16'($urandom_range(0, int'(period) + 2));
        compare2 = 16'($urandom_range(0, int'(period) + 2));
      end
      if ($urandom_range(0, 99) == 0) pwm_en = ~pwm_en;
      if ($urandom_range(0, 3) != 0) begin
        if (cnt > int'(period)) cnt = 0;
        else if (upnotdown) cnt = (cnt == int'(period)) ? 0 : cnt + 1;
        else cnt = (cnt == 0) ? int'(period) : cnt - 1;
      end
      count_val = 16'(cnt);
      step();
      check("rand_pwm", pwm_out, m_pwm);
      check("rand_tick", period_tick, m_tick);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
